// File: rtl/ram_ctrl_pkg.sv
// Shared state type and default geometry for the RAM access controller.
package ram_ctrl_pkg;

    localparam int unsigned RAM_CTRL_DATA_W = 8;
    localparam int unsigned RAM_CTRL_ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RSP,
        CLR
    } ram_ctrl_state_e;

endpackage

// File: rtl/ram_access_ctrl.sv
// Single-request controller in front of an asynchronous RAM; one access per accepted request.
// Define RAM_ACCESS_CTRL_CLR_EN to zero the whole RAM after every reset (busy while sweeping).
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_CTRL_DATA_W,
    parameter int unsigned ADDR_W = RAM_CTRL_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    ram_ctrl_state_e   state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    // addr_q doubles as the sweep counter; wdata_q is still zero from reset during the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef RAM_ACCESS_CTRL_CLR_EN
            state_q <= CLR;
`else
            state_q <= IDLE;
`endif
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        if (req_write) begin
                            wdata_q <= req_wdata;
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                WR: state_q <= IDLE;
                RD: begin
                    rdata_q <= ram_data_out;
                    state_q <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
`ifdef RAM_ACCESS_CTRL_CLR_EN
                CLR: begin
                    if (addr_q == '1) begin
                        state_q <= IDLE;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE) && !rst;
    assign rsp_valid   = (state_q == RSP);
    assign rsp_rdata   = rdata_q;
    assign ram_addr    = addr_q;
    assign ram_data_in = wdata_q;
    assign ram_re      = (state_q == RD);

`ifdef RAM_ACCESS_CTRL_CLR_EN
    assign busy   = (state_q == CLR) && !rst;
    assign ram_we = (state_q == WR) || busy;
`else
    assign busy   = 1'b0;
    assign ram_we = (state_q == WR);
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomised and directed bench for ram_access_ctrl against a cycle-timeline reference model.
// Honours RAM_ACCESS_CTRL_CLR_EN the same way the design does.
`timescale 1ns/1ps
module tb_ram_access_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef RAM_ACCESS_CTRL_CLR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready, rsp_valid, ram_we, ram_re, busy;
    logic [DW-1:0] rsp_rdata, ram_data_in, ram_data_out;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] mdl_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_re(ram_re),
        .ram_data_out(ram_data_out), .busy(busy)
    );

    // Environment: asynchronous-read RAM behind the controller.
    assign ram_data_out = ram_mem[ram_addr];
    always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_data_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding request plus the cycle it was accepted in.
    typedef enum logic [1:0] {M_NONE, M_WR, M_RD} mop_e;
    mop_e          m_op      = M_NONE;
    int unsigned   m_cyc     = 0;
    int unsigned   m_acc     = 0;
    int unsigned   m_clr_idx = 0;
    bit            m_clr     = 1'b0;
    bit            m_applied = 1'b0;
    logic [AW-1:0] m_addr    = '0;
    logic [DW-1:0] m_wdata   = '0;
    logic [DW-1:0] m_rdata   = '0;

    initial begin : compare
        bit            e_clr, e_rv;
        logic [AW-1:0] e_addr;
        forever begin
            @(negedge clk);
            if (rst && !m_applied) begin
                chk("ready_low_on_rst", req_ready, 0);
            end else begin
                e_clr  = m_clr && !rst;
                e_rv   = (m_op == M_RD) && (m_cyc >= m_acc + 2);
                e_addr = m_clr ? AW'(m_clr_idx) : m_addr;
                chk("req_ready",   req_ready,   !rst && (m_op == M_NONE) && !m_clr);
                chk("busy",        busy,        e_clr);
                chk("ram_we",      ram_we,      e_clr || (m_op == M_WR));
                chk("ram_re",      ram_re,      (m_op == M_RD) && (m_cyc == m_acc + 1));
                chk("rsp_valid",   rsp_valid,   e_rv);
                chk("rsp_rdata",   rsp_rdata,   m_rdata);
                chk("ram_addr",    ram_addr,    e_addr);
                chk("ram_data_in", ram_data_in, m_clr ? '0 : m_wdata);
            end
            m_applied = (rst === 1'b1);
            if (rst) begin
                m_op = M_NONE; m_addr = '0; m_wdata = '0; m_rdata = '0;
                m_clr = CLR_EN; m_clr_idx = 0;
            end else if (m_clr) begin
                mdl_mem[m_clr_idx] = '0;
                if (m_clr_idx == DEPTH - 1) begin
                    m_clr  = 1'b0;
                    m_addr = '1;
                end else begin
                    m_clr_idx++;
                end
            end else begin
                case (m_op)
                    M_NONE: if (req_valid) begin
                        m_addr = req_addr;
                        m_acc  = m_cyc;
                        if (req_write) begin m_wdata = req_wdata; m_op = M_WR; end
                        else m_op = M_RD;
                    end
                    M_WR: begin mdl_mem[m_addr] = m_wdata; m_op = M_NONE; end
                    default: begin
                        if (m_cyc == m_acc + 1) m_rdata = mdl_mem[m_addr];
                        else if (rsp_ready) m_op = M_NONE;
                    end
                endcase
            end
            m_cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (!req_ready && n < limit) begin step(); n++; end
        chk("wait_ready_timeout", req_ready, 1);
    endtask

    // Presents a request until accepted; returns one cycle after acceptance.
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        wait_ready(50);
        step();
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int unsigned hold);
        rsp_ready = 1'b0;
        issue(1'b0, a, '0);
        chk("rd_re_pulse", ram_re, 1);
        chk("rd_addr", ram_addr, a);
        step();
        for (int unsigned i = 0; i < hold; i++) begin
            chk("rd_hold_valid", rsp_valid, 1);
            chk("rd_hold_data", rsp_rdata, exp);
            chk("rd_hold_ready_low", req_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        chk("rd_valid", rsp_valid, 1);
        chk("rd_data", rsp_rdata, exp);
        step();
        rsp_ready = 1'b0;
        chk("rd_idle_after_rsp", req_ready, 1);
        chk("rd_valid_dropped", rsp_valid, 0);
    endtask

    initial begin : stim
        int unsigned n_busy, acc_n, pulses, r;
        bit          wr, safe;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ram_mem[i] = DW'(i * 7 + 3);
            mdl_mem[i] = DW'(i * 7 + 3);
        end
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        #1;
`ifdef RAM_ACCESS_CTRL_CLR_EN
        n_busy = 0;
        while (busy && n_busy < 2000) begin n_busy++; step(); end
        chk("clr_busy_cycles", n_busy, 1024);
        read_chk(10'd512, 8'h00, 0);
`else
        chk("ready_first_cycle", req_ready, 1);
        chk("busy_tied_low", busy, 0);
        step();
`endif

        issue(1'b1, 10'd0, 8'hA9);
        chk("wr_we", ram_we, 1);
        chk("wr_re_low", ram_re, 0);
        chk("wr_addr", ram_addr, 0);
        chk("wr_data", ram_data_in, 8'hA9);
        step();
        chk("wr_we_single", ram_we, 0);
        read_chk(10'd0, 8'hA9, 0);

        issue(1'b1, 10'd1, 8'h02);
        issue(1'b1, 10'd1023, 8'h55);
        read_chk(10'd1, 8'h02, 0);
        read_chk(10'd1023, 8'h55, 0);
        read_chk(10'd1023, 8'h55, 5);

        rsp_ready = 1'b0;
        issue(1'b0, 10'd1, '0);
        step();
        chk("abort_in_rsp", rsp_valid, 1);
        rst = 1'b1;
        step();
        chk("abort_valid", rsp_valid, 0);
        chk("abort_we", ram_we, 0);
        chk("abort_re", ram_re, 0);
        chk("abort_rdata", rsp_rdata, 0);
        rst = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            chk("abort_no_rsp", rsp_valid, 0);
            chk("abort_no_re", ram_re, 0);
`ifndef RAM_ACCESS_CTRL_CLR_EN
            chk("abort_no_we", ram_we, 0);
`endif
            step();
        end
        wait_ready(2000);

        // Back-to-back traffic with valid held high, write/read alternating per acceptance.
        rsp_ready = 1'b1; req_valid = 1'b1; wr = 1'b1; acc_n = 0; pulses = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            req_write = wr; req_addr = AW'($urandom_range(0, 7)); req_wdata = DW'($urandom);
            if (ram_we || ram_re) pulses++;
            chk("b2b_exclusive", ram_we && ram_re, 0);
            if (req_ready) begin acc_n++; wr = !wr; end
            step();
        end
        req_valid = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (ram_we || ram_re) pulses++;
            step();
        end
        chk("b2b_pulse_count", pulses, acc_n);
        chk("b2b_progress", acc_n >= 12, 1);

        for (int unsigned i = 0; i < 600; i++) begin
            safe = (m_op == M_NONE) || ((m_op == M_RD) && (m_cyc >= m_acc + 2));
            if (!CLR_EN && safe && $urandom_range(0, 59) == 0) begin
                rst = 1'b1; req_valid = 1'($urandom);
                step();
                if ($urandom_range(0, 1) == 1) step();
                rst = 1'b0;
            end
            r = $urandom_range(0, 7);
            req_valid = ($urandom_range(0, 9) < 7);
            req_write = 1'($urandom);
            req_addr  = (r == 0) ? '0 : (r == 1) ? '1 : (r < 5) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            req_wdata = DW'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end

        req_valid = 1'b0; rsp_ready = 1'b1;
        step(); step(); step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: RAM data width.
REQ-002 SHALL have parameter ADDR_W, default 10: RAM address width (depth 2**ADDR_W).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1: request present.
REQ-006 SHALL have port req_ready  output  1: request accepted this cycle if req_valid also high.
REQ-007 SHALL have port req_write  input  1: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W: request address.
REQ-009 SHALL have port req_wdata  input  DATA_W: write data.
REQ-010 SHALL have port rsp_valid  output  1: read data available.
REQ-011 SHALL have port rsp_ready  input  1: consumer takes response.
REQ-012 SHALL have port rsp_rdata  output  DATA_W: read data.
REQ-013 SHALL have ports ram_addr  output  ADDR_W, ram_data_in  output  DATA_W, ram_we  output  1, ram_re  output  1: drive the downstream asynchronous RAM.
REQ-014 SHALL have port ram_data_out  input  DATA_W: combinational RAM read data.
REQ-015 SHALL have port busy  output  1: clear sweep in progress.

Function
REQ-016 SHALL implement FSM states IDLE, WR, RD, RSP, CLR.
REQ-017 SHALL assert req_ready only in IDLE; handshake = req_valid && req_ready.
REQ-018 SHALL, on handshake with req_write=1, register addr/wdata and enter WR; ram_we=1 for exactly one cycle (cycle N+1 for acceptance at N), then IDLE.
REQ-019 SHALL, on handshake with req_write=0, register addr and enter RD; ram_re=1 for exactly one cycle (N+1), capturing ram_data_out at the end of that cycle.
REQ-020 SHALL, after RD, enter RSP with rsp_valid=1 from cycle N+2, rsp_rdata stable, until rsp_ready=1; then IDLE the following cycle.
REQ-021 SHALL never assert ram_we and ram_re in the same cycle; both 0 in IDLE and RSP.
REQ-022 SHALL hold ram_addr/ram_data_in at the registered request values while in WR/RD; unchanged otherwise.
REQ-023 SHALL ignore req_* inputs while req_ready=0 (no queuing; upstream holds).
REQ-024 SHALL accept req_addr at boundary values 0 and 2**ADDR_W-1 without wrap or truncation.
REQ-025 SHALL make rsp_rdata valid only while rsp_valid=1; value otherwise retains last capture.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, abort any operation: req_ready=0, rsp_valid=0, ram_we=0, ram_re=0, ram_addr=0, ram_data_in=0, rsp_rdata=0, busy=0 during reset.
REQ-027 SHALL, on the first cycle after rst deasserts, enter IDLE (or CLR per REQ-029); a read aborted mid-RSP SHALL produce no response.

Configuration
REQ-028 SHALL compile the clear sweep only when macro RAM_ACCESS_CTRL_CLR_EN is defined.
REQ-029 SHALL, with RAM_ACCESS_CTRL_CLR_EN, enter CLR after reset: write 0 to addresses 0..2**ADDR_W-1, one per cycle, ram_we=1, busy=1, req_ready=0; enter IDLE after the last address (2**ADDR_W cycles); rst during CLR restarts the sweep from 0.
REQ-030 SHALL, without RAM_ACCESS_CTRL_CLR_EN, go directly to IDLE after reset, tie busy=0, never enter CLR.

Structure
REQ-031 SHALL place the FSM state enum and default DATA_W/ADDR_W constants in shared package ram_ctrl_pkg.
REQ-032 SHALL be a single module; sweep counter inline, no sub-module; RAM itself instantiated outside.

Verification
REQ-033 Write 0xA9 to addr 0, then read addr 0 -> ram_we one cycle with addr 0/data 0xA9; rsp_valid two cycles after read acceptance, rsp_rdata=0xA9.
REQ-034 Write 0x02 to addr 1, write 0x55 to 1023, read both -> rsp_rdata 0x02 then 0x55, no address aliasing.
REQ-035 Read accepted, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable 5 cycles, req_ready=0 throughout; release -> IDLE next cycle.
REQ-036 rst asserted while in RSP -> rsp_valid=0 next cycle, no response later, ram_we/ram_re stay 0.
REQ-037 With RAM_ACCESS_CTRL_CLR_EN, after reset -> busy=1 for 1024 cycles, then read of addr 512 returns 0x00; without macro, req_ready=1 first cycle after reset.
REQ-038 Back-to-back req_valid held high with alternating write/read -> exactly one ram_we or ram_re pulse per accepted request, never both in one cycle.
